uart_tx_port: RTL and testbench

- Serial output port for the 8-bit processor.
- Drains bytes written by the datapath (same `data`/`load` write strobe the register bank uses) and transmits them as 8N1 asynchronous serial frames, LSB first.
- One-byte holding buffer behind the shift register allows back-to-back frames with no idle gap.
- Sits on the processor's output bus; `tx` goes to the board pin.

---
 rtl/uart_tx_port_if.sv | 12 +
 rtl/uart_tx_port.sv | 106 ++++++++++
 tb/tb_uart_tx_port.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_port_if.sv
// uart_tx_port_if: write strobe and serial-line status bundle between the datapath and the UART transmitter
interface uart_tx_port_if;
    logic [7:0] data;
    logic       load;
    logic       tx;
    logic       busy;
    logic       ready;
    logic       done;

    modport master (output data, load, input tx, busy, ready, done);
    modport slave  (input data, load, output tx, busy, ready, done);
endinterface

// File: rtl/uart_tx_port.sv
// uart_tx_port: 8N1 LSB-first serial transmitter with a one-byte holding buffer for gapless frames
module uart_tx_port #(
    parameter int CLKS_PER_BIT = 16
) (
    input logic           clk,
    input logic           rst_n,
    uart_tx_port_if.slave bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, buf_q, buf_d;
    logic          ready_q, ready_d, tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic          accept, last;

    assign accept = bus.load && ready_q;
    assign last   = baud_q == BW'(CLKS_PER_BIT - 1);

    // Frame sequencing, baud/bit counting and holding-buffer management; tx/busy follow the next state
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        buf_d   = buf_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        baud_d  = (state_q == IDLE || last) ? '0 : baud_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shift_d = bus.data;
                end
            end
            START: begin
                if (last) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (last) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                if (last) begin
                    done_d = 1'b1;
                    if (!ready_q) begin
                        state_d = START;
                        shift_d = buf_q;
                        ready_d = 1'b1;
                    end else if (accept) begin
                        state_d = START;
                        shift_d = bus.data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept && state_q != IDLE && !(state_q == STOP && last)) begin
            buf_d   = bus.data;
            ready_d = 1'b0;
        end
        tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
        busy_d = state_d != IDLE;
    end

    // State register; reset drops any frame in flight and the buffered byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            buf_q   <= '0;
            ready_q <= 1'b1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            buf_q   <= buf_d;
            ready_q <= ready_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx    = tx_q;
    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed scenarios with literal expectations plus randomized traffic against a frame-level model
module tb_uart_tx_port;
    localparam int C     = 4;
    localparam int FRAME = 10 * C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_port_if bus ();
    uart_tx_port #(.CLKS_PER_BIT(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int         pos     = -1;
    logic [9:0] frame   = '1;
    logic [7:0] m_buf   = '0;
    logic       m_full  = 1'b0;
    logic       m_done  = 1'b0;
    logic       m_valid = 1'b0;

    logic       tx_l[0:127], busy_l[0:127], ready_l[0:127], done_l[0:127];
    int         ld_c[$];
    logic [7:0] ld_d[$];
    int         rst_c = -1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Frame-level model: a frame is the 10-bit word {stop, byte, start} played for FRAME cycles
    always @(posedge clk) begin : mdl
        logic acc;
        acc = bus.load && !m_full;
        if (!rst_n) begin
            pos    = -1;
            m_full = 1'b0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (pos == FRAME - 1) begin
                m_done = 1'b1;
                if (m_full) begin
                    frame  = {1'b1, m_buf, 1'b0};
                    m_full = 1'b0;
                    pos    = 0;
                end else if (acc) begin
                    frame = {1'b1, bus.data, 1'b0};
                    pos   = 0;
                end else begin
                    pos = -1;
                end
            end else if (pos >= 0) begin
                pos++;
                if (acc) begin
                    m_buf  = bus.data;
                    m_full = 1'b1;
                end
            end else if (acc) begin
                frame = {1'b1, bus.data, 1'b0};
                pos   = 0;
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_tx", bus.tx, (pos < 0) ? 1'b1 : frame[pos / C]);
            chk("model_busy", bus.busy, pos >= 0);
            chk("model_ready", bus.ready, !m_full);
            chk("model_done", bus.done, m_done);
        end
    end

    task automatic seq(int n);
        for (int i = 0; i < n; i++) begin
            bus.load = 1'b0;
            foreach (ld_c[k]) begin
                if (ld_c[k] == i) begin
                    bus.load = 1'b1;
                    bus.data = ld_d[k];
                end
            end
            rst_n = (i != rst_c);
            @(negedge clk);
            tx_l[i+1]    = bus.tx;
            busy_l[i+1]  = bus.busy;
            ready_l[i+1] = bus.ready;
            done_l[i+1]  = bus.done;
        end
        bus.load = 1'b0;
        rst_n    = 1'b1;
        ld_c.delete();
        ld_d.delete();
        rst_c = -1;
    endtask

    task automatic add_load(int c, logic [7:0] d);
        ld_c.push_back(c);
        ld_d.push_back(d);
    endtask

    function automatic logic [7:0] decode(int s);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = tx_l[s + C + C * j + 1];
        return r;
    endfunction

    function automatic int low_tx(int a, int b);
        int z = 0;
        for (int i = a; i <= b; i++) z += (tx_l[i] == 1'b0) ? 1 : 0;
        return z;
    endfunction

    function automatic int low_busy(int a, int b);
        int z = 0;
        for (int i = a; i <= b; i++) z += (busy_l[i] == 1'b0) ? 1 : 0;
        return z;
    endfunction

    initial begin
        logic pat[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bus.load = 1'b1;
        bus.data = 8'hFF;
        rst_n    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", bus.tx, 1);
            chk("rst_busy", bus.busy, 0);
            chk("rst_ready", bus.ready, 1);
            chk("rst_done", bus.done, 0);
        end
        rst_n    = 1'b1;
        bus.load = 1'b0;
        seq(8);
        chk("post_rst_idle_tx", low_tx(1, 8), 0);
        chk("post_rst_idle_busy", low_busy(1, 8), 8);

        add_load(0, 8'hA5);
        seq(45);
        for (int b = 0; b < 10; b++)
            chk($sformatf("a5_bit%0d", b), {tx_l[1+4*b], tx_l[2+4*b], tx_l[3+4*b], tx_l[4+4*b]}, pat[b] ? 4'hF : 4'h0);
        chk("a5_done40", done_l[40], 0);
        chk("a5_done41", done_l[41], 1);
        chk("a5_done42", done_l[42], 0);
        chk("a5_busy40", busy_l[40], 1);
        chk("a5_busy41", busy_l[41], 0);
        chk("a5_ready1", ready_l[1], 1);

        add_load(0, 8'h00);
        add_load(5, 8'hFF);
        seq(86);
        chk("b2b_ready5", ready_l[5], 1);
        chk("b2b_ready6", ready_l[6], 0);
        chk("b2b_ready40", ready_l[40], 0);
        chk("b2b_ready41", ready_l[41], 1);
        chk("b2b_tx40", tx_l[40], 1);
        chk("b2b_tx41", tx_l[41], 0);
        chk("b2b_busy41", busy_l[41], 1);
        chk("b2b_done41", done_l[41], 1);
        chk("b2b_done81", done_l[81], 1);
        chk("b2b_byte1", decode(1), 8'h00);
        chk("b2b_byte2", decode(41), 8'hFF);

        add_load(0, 8'h11);
        add_load(2, 8'h22);
        add_load(4, 8'h33);
        seq(90);
        chk("ovf_ready4", ready_l[4], 0);
        chk("ovf_byte1", decode(1), 8'h11);
        chk("ovf_byte2", decode(41), 8'h22);
        chk("ovf_busy81", busy_l[81], 0);
        chk("ovf_no_third", low_tx(81, 90), 0);

        add_load(0, 8'h3C);
        add_load(40, 8'h5A);
        seq(86);
        chk("coin_tx41", tx_l[41], 0);
        chk("coin_done41", done_l[41], 1);
        chk("coin_busy_gap", low_busy(1, 80), 0);
        chk("coin_byte2", decode(41), 8'h5A);

        add_load(0, 8'hC3);
        add_load(3, 8'h77);
        rst_c = 18;
        seq(60);
        chk("mrst_ready18", ready_l[18], 0);
        chk("mrst_tx19", tx_l[19], 1);
        chk("mrst_ready19", ready_l[19], 1);
        chk("mrst_busy19", busy_l[19], 0);
        chk("mrst_done19", done_l[19], 0);
        chk("mrst_idle", low_tx(19, 60), 0);

        for (int i = 0; i < 3000; i++) begin
            bus.load = $urandom_range(0, 5) == 0;
            bus.data = 8'($urandom);
            rst_n    = $urandom_range(0, 999) != 0;
            @(negedge clk);
        end
        bus.load = 1'b0;
        rst_n    = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
